cat_recognizer_sequencer: RTL
=============================

# cat_recognizer_sequencer

Sequencer that drives one classification pass of the cat recognizer. On a start pulse from the APB register file it walks the pixel and weight memories word by word and accumulates the signed dot product of three 8-bit pixels and three signed weights per word. It then adds a bias and produces a one-bit cat/not-cat decision. It shares the memories with the APB slave: APB has priority and the sequencer reads only when granted.

## Interface
- Amba_Word, 24, memory/APB word width; each pixel word holds 3 pixels, each weight word holds 3 weights
- Amba_Addr_Depth, 13, memory address width and width of num_words
- Weight_precision, 5, width of one signed two's-complement weight
- Local ACC_W = 8 + Weight_precision + 2 + Amba_Addr_Depth (28 at defaults)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that starts a pass; ignored while busy
- num_words  in  Amba_Addr_Depth  number of word pairs to process; sampled on start
- bias  in  Amba_Word  signed bias, sign-extended to ACC_W+1; sampled on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result and score are valid from this cycle
- result  out  1  1 = cat (score > 0); held until the next done
- score  out  ACC_W+1  signed acc + bias; held until the next done
- mem_rd_en  out  1  read request to both memories
- mem_addr  out  Amba_Addr_Depth  read address; held stable until granted
- mem_gnt  in  1  arbiter grant; a read is taken in a cycle with mem_rd_en && mem_gnt
- pixel_rdata  in  Amba_Word  pixel word, valid the cycle after the granted read
- weight_rdata  in  Amba_Word  weight word, same timing as pixel_rdata

## Operation
- Packing: pixel k = pixel_rdata[8k+7:8k], unsigned. Weight k = weight_rdata[Weight_precision*(k+1)-1 : Weight_precision*k], signed. k = 0..2. Unused upper bits are ignored.
- Per valid word: acc += p0*w0 + p1*w1 + p2*w2, signed, at full ACC_W width, no saturation.
- FSM states: IDLE, FETCH, DRAIN, DECIDE.
  - IDLE: on start, latch num_words and bias, clear acc, set mem_addr=0. Go to FETCH, or to DECIDE if num_words==0.
  - FETCH: mem_rd_en=1. On each grant, mem_addr increments. The grant of address num_words-1 moves the FSM to DRAIN.
  - DRAIN: no request; the last word is accumulated this cycle. Go to DECIDE.
  - DECIDE: score <= acc + bias, result <= (score > 0), done <= 1. Go to IDLE.
- rd_valid is a register set the cycle after a granted read. acc updates only when rd_valid=1; a missing grant inserts a bubble without losing data.
- mem_rd_en is 0 in every state except FETCH. mem_addr never exceeds num_words-1.
- Start in any non-IDLE state is ignored and has no effect on the latched values.

## Timing
- Reset values: busy=0, done=0, result=0, score=0, mem_rd_en=0, mem_addr=0, acc=0, FSM in IDLE.
- Reset asserted mid-pass aborts immediately. done is not pulsed, result and score clear to 0, and the next start behaves as from cold.
- Start sampled in cycle T:
  - Cycles T+1..T+N: FETCH, mem_rd_en=1 (continuous grant), mem_addr = 0..N-1.
  - Cycle T+N+1: DRAIN.
  - Cycle T+N+2: DECIDE.
  - Cycle T+N+3: done=1, busy=0, result and score valid.
- Start-to-done latency is N+3 cycles with continuous grant. Each cycle in FETCH with mem_gnt=0 adds exactly one cycle.
- num_words=0: DECIDE at T+1, done at T+2, score=bias.
- Start in the same cycle as done: accepted, since the FSM is already in IDLE. busy rises in the next cycle.

## Test plan
- N=1, pixel 0x0A0B0C, weight 0x000BE1 (w0=1, w1=-1, w2=2):
  - bias=-21 -> score=0, result=0 (strict >0 boundary);
  - bias=-20 -> score=1, result=1;
  - done exactly 4 cycles after start.
- N=8191, every pixel 0xFFFFFF, every weight 0x4210 (all -16), bias=0 -> score=-100257840, result=0, no overflow, done 8194 cycles after start.
- N=4 with mem_gnt low on alternate FETCH cycles:
  - mem_addr holds while ungranted;
  - all 4 words accumulate exactly once;
  - done arrives 4 cycles later than the continuous-grant case.
- num_words=0, bias=5 -> mem_rd_en never asserted, done at T+2, score=5, result=1.
- A start pulse mid-pass is ignored (latched N and bias unchanged), and a start in the done cycle is accepted.
- rst asserted at cycle T+3 of an N=10 pass -> all outputs 0 next cycle and no done. A following N=1 pass gives the correct score.

Source files
------------

// File: rtl/cat_recognizer_sequencer.sv
// Cat recognizer sequencer: walks pixel/weight memories, accumulates the dot
// product, adds a bias and emits a one-bit cat decision.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse that starts a pass (ignored while busy)
//   num_words, bias     pass length and signed bias, latched on start
//   busy, done          pass in progress / one-cycle completion pulse
//   result, score       decision (score > 0) and signed acc + bias, held
//   mem_rd_en, mem_addr read request and address to both memories
//   mem_gnt             arbiter grant (APB has priority)
//   pixel_rdata         pixel word, valid the cycle after a granted read
//   weight_rdata        weight word, same timing as pixel_rdata
module cat_recognizer_sequencer #(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 13,
  parameter int Weight_precision = 5,
  localparam int ACC_W = 8 + Weight_precision + 2 + Amba_Addr_Depth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [Amba_Addr_Depth-1:0] num_words,
  input  logic [Amba_Word-1:0]       bias,
  output logic                       busy,
  output logic                       done,
  output logic                       result,
  output logic signed [ACC_W:0]      score,
  output logic                       mem_rd_en,
  output logic [Amba_Addr_Depth-1:0] mem_addr,
  input  logic                       mem_gnt,
  input  logic [Amba_Word-1:0]       pixel_rdata,
  input  logic [Amba_Word-1:0]       weight_rdata
);

  localparam int AD = Amba_Addr_Depth;
  localparam int AW = Amba_Word;
  localparam int WP = Weight_precision;
  localparam int SW = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DECIDE
  } state_t;

  state_t state_q, state_d;

  logic [AD-1:0] num_q, num_d;
  logic [AD-1:0] addr_q, addr_d;
  logic [AW-1:0] bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic rd_valid_q, rd_valid_d;
  logic done_q, done_d;
  logic result_q, result_d;
  logic signed [SW-1:0] score_q, score_d;

  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] wt_ext;
  logic signed [ACC_W-1:0] word_sum;
  logic signed [SW-1:0] bias_ext;
  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] sum;
  logic last;
  logic unused_wt_bits;

  // weight bits above the three packed weights carry no data
  assign unused_wt_bits = ^weight_rdata[AW-1:3*WP];

  // pixels are unsigned, so zero-extend before the signed multiply
  always_comb begin
    pix_ext  = '0;
    wt_ext   = '0;
    word_sum = '0;
    for (int k = 0; k < 3; k++) begin
      pix_ext = {{(ACC_W-8){1'b0}}, pixel_rdata[8*k +: 8]};
      wt_ext  = {{(ACC_W-WP){weight_rdata[WP*k+WP-1]}},
                 weight_rdata[WP*k +: WP]};
      word_sum = word_sum + pix_ext * wt_ext;
    end
  end

  assign bias_ext = {{(SW-AW){bias_q[AW-1]}}, bias_q};
  assign acc_ext  = {acc_q[ACC_W-1], acc_q};
  assign sum      = acc_ext + bias_ext;
  assign last     = (addr_q == num_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    bias_d     = bias_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    result_d   = result_q;
    score_d    = score_q;
    mem_rd_en  = 1'b0;

    // data returns one cycle after its grant, including in DRAIN
    if (rd_valid_q) begin
      acc_d = acc_q + word_sum;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_words;
          bias_d  = bias;
          acc_d   = '0;
          addr_d  = '0;
          state_d = (num_words == '0) ? DECIDE : FETCH;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        if (mem_gnt) begin
          rd_valid_d = 1'b1;
          if (last) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = DECIDE;
      end
      DECIDE: begin
        score_d  = sum;
        result_d = !sum[SW-1] && (sum != '0);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      addr_q     <= '0;
      bias_q     <= '0;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 1'b0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      addr_q     <= addr_d;
      bias_q     <= bias_d;
      acc_q      <= acc_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      result_q   <= result_d;
      score_q    <= score_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign score    = score_q;
  assign mem_addr = addr_q;

endmodule
